z_result_fifo: RTL and testbench

- Downstream buffer for the signed 64-bit datapath circuits. It captures the registered result z, qualified by a valid strobe, into a small FIFO.
- It presents results to the consumer over a valid/ready handshake, so a stalled consumer does not lose results while storage remains.
- When full with no pop, it drops the incoming result and records it in a sticky overflow flag and a saturating drop counter.

---
 rtl/z_result_fifo_pkg.sv | 29 ++
 rtl/z_fifo_mem.sv | 33 +++
 rtl/z_result_fifo.sv | 112 +++++++++++
 tb/tb_z_result_fifo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/z_result_fifo_pkg.sv
// ---------------------------------------------------------------------------
// z_result_fifo_pkg : shared widths, FIFO state encoding and clog2 helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package z_result_fifo_pkg;

  localparam int DATAWIDTH_DEF = 64;
  localparam int DROPWIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/z_fifo_mem.sv
// ---------------------------------------------------------------------------
// z_fifo_mem : DEPTH x DATAWIDTH register array, sync write, async read
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module z_fifo_mem
  import z_result_fifo_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int DEPTH     = 4,
  parameter int ADDRWIDTH = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [DATAWIDTH-1:0] rdata
);

  // Storage is deliberately left out of reset; validity is tracked by the pointers.
  logic [DATAWIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/z_result_fifo.sv
// ---------------------------------------------------------------------------
// z_result_fifo : show-ahead result FIFO with sticky overflow and drop counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module z_result_fifo
  import z_result_fifo_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int DEPTH     = 4,
  parameter int ADDRWIDTH = clog2(DEPTH),
  parameter int DROPWIDTH = DROPWIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATAWIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic signed [DATAWIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        clr_ovf,
  output logic        [ADDRWIDTH:0]   count,
  output logic                        full,
  output logic                        overflow,
  output logic        [DROPWIDTH-1:0] drop_count
);

  localparam logic [ADDRWIDTH:0]   C_DEPTH    = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [DROPWIDTH-1:0] C_DROP_MAX = '1;

  logic [ADDRWIDTH-1:0] r_wr_ptr;
  logic [ADDRWIDTH-1:0] r_rd_ptr;
  logic [ADDRWIDTH:0]   r_count;
  fifo_state_e          r_state;
  logic                 r_overflow;
  logic [DROPWIDTH-1:0] r_drop_count;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;
  logic [ADDRWIDTH:0]   w_count_nxt;
  fifo_state_e          w_state_nxt;
  logic [DROPWIDTH-1:0] w_drop_inc;
  logic [DATAWIDTH-1:0] w_rdata;

  assign w_pop  = out_valid && out_ready;
  assign w_push = in_valid && (!full || w_pop);
  assign w_drop = in_valid && full && !w_pop;

  assign w_drop_inc = (r_drop_count == C_DROP_MAX) ? r_drop_count
                                                   : r_drop_count + DROPWIDTH'(1);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + (ADDRWIDTH+1)'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - (ADDRWIDTH+1)'(1);
  end

  always_comb begin
    w_state_nxt = ST_PARTIAL;
    if (w_count_nxt == '0)          w_state_nxt = ST_EMPTY;
    else if (w_count_nxt == C_DEPTH) w_state_nxt = ST_FULL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_state      <= ST_EMPTY;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDRWIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDRWIDTH'(1);
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
      // A drop in the same cycle as a clear restarts the tally at one.
      if (w_drop) begin
        r_overflow   <= 1'b1;
        r_drop_count <= clr_ovf ? DROPWIDTH'(1) : w_drop_inc;
      end else if (clr_ovf) begin
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end
    end
  end

  z_fifo_mem #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  assign out_valid  = (r_state != ST_EMPTY);
  assign full       = (r_state == ST_FULL);
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign out_data   = out_valid ? w_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_z_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_z_result_fifo : directed stimulus with scoreboard queue and pop monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_z_result_fifo;

  logic               clk;
  logic               rst;
  logic signed [63:0] in_data;
  logic               in_valid;
  logic signed [63:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               clr_ovf;
  logic [2:0]         count;
  logic               full;
  logic               overflow;
  logic [15:0]        drop_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sbq [$];

  z_result_fifo #(
    .DATAWIDTH (64),
    .DEPTH     (4),
    .ADDRWIDTH (2),
    .DROPWIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_ovf    (clr_ovf),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; handshakes are judged at the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got %h expected no data", out_data);
      end else begin
        check("pop_data", out_data, sbq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input bit accepted);
    in_valid = 1'b1;
    in_data  = d;
    if (accepted) sbq.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data"}, out_data, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) tick();
    check_empty("rst");
    check("rst_full", 64'(full), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    rst = 1'b1;
    tick();
    check_empty("idle");

    // latency and ordering
    push(64'sh0000000000000005, 1'b1);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_data", out_data, 64'd5);
    push(-64'sd1, 1'b1);
    check("lat_count", 64'(count), 64'd2);
    check("lat_head", out_data, 64'd5);
    drain(2);
    check_empty("lat_end");

    // fill and overflow
    for (int i = 10; i <= 13; i++) push(64'(i), 1'b1);
    check("fill_count", 64'(count), 64'd4);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ovf0", 64'(overflow), 64'd0);
    push(64'd14, 1'b0);
    check("drop_count4", 64'(count), 64'd4);
    check("drop_ovf", 64'(overflow), 64'd1);
    check("drop_cnt", 64'(drop_count), 64'd1);
    drain(4);
    check_empty("fill_end");

    // simultaneous push/pop while full
    for (int i = 10; i <= 13; i++) push(64'(i), 1'b1);
    out_ready = 1'b1;
    push(64'd20, 1'b1);
    out_ready = 1'b0;
    check("pp_count", 64'(count), 64'd4);
    check("pp_drop", 64'(drop_count), 64'd1);
    check("pp_head", out_data, 64'd11);
    drain(4);
    check_empty("pp_end");

    // clear alone, then clear colliding with a drop
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_drop", 64'(drop_count), 64'd0);
    for (int i = 30; i <= 33; i++) push(64'(i), 1'b1);
    clr_ovf = 1'b1;
    push(64'd99, 1'b0);
    clr_ovf = 1'b0;
    check("clrdrop_ovf", 64'(overflow), 64'd1);
    check("clrdrop_cnt", 64'(drop_count), 64'd1);
    drain(4);
    check_empty("clrdrop_end");

    // asynchronous reset with data buffered
    for (int i = 40; i <= 42; i++) push(64'(i), 1'b1);
    check("mid_count3", 64'(count), 64'd3);
    #1 rst = 1'b0;
    #1;
    check("mid_count", 64'(count), 64'd0);
    check("mid_valid", 64'(out_valid), 64'd0);
    check("mid_ovf", 64'(overflow), 64'd0);
    sbq.delete();
    #1 rst = 1'b1;
    tick();
    push(64'd77, 1'b1);
    check("post_head", out_data, 64'd77);
    check("post_count", 64'(count), 64'd1);
    drain(1);
    check_empty("post_end");
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
